// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero and is never marked busy.
// Reads are combinational. Optional same-cycle write-to-read bypass is
// compiled in when REGFILE_MP_BYPASS_EN is defined. Without it, a read in
// the write cycle returns the pre-edge value.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NWR-1:0]           we,
    input  logic [NWR*ADDR_W-1:0]    wa,
    input  logic [NWR*DATA_W-1:0]    wd,
    input  logic [NRD*ADDR_W-1:0]    ra,
    output logic [NRD*DATA_W-1:0]    rd,
    input  logic                     bset,
    input  logic [ADDR_W-1:0]        bset_a,
    output logic [NRD-1:0]           rbusy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem      [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    logic [ADDR_W-1:0] wa_a     [NWR];
    logic [DATA_W-1:0] wd_a     [NWR];
    logic [NWR-1:0]    wr_hit;
    logic [ADDR_W-1:0] ra_a     [NRD];
    logic              set_hit;

    // Unpack write ports; a write to address 0 is treated as no write at all.
    always_comb begin
        for (int unsigned i = 0; i < NWR; i++) begin
            wa_a[i]   = wa[i*ADDR_W +: ADDR_W];
            wd_a[i]   = wd[i*DATA_W +: DATA_W];
            wr_hit[i] = we[i] && (wa_a[i] != '0);
        end
    end

    // Unpack read addresses.
    always_comb begin
        for (int unsigned j = 0; j < NRD; j++) begin
            ra_a[j] = ra[j*ADDR_W +: ADDR_W];
        end
    end

    assign set_hit = bset && (bset_a != '0);

    // Register storage; higher-indexed ports are applied later so they win conflicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NWR; i++) begin
                if (wr_hit[i]) begin
                    mem[wa_a[i]] <= wd_a[i];
                end
            end
        end
    end

    // Scoreboard next state: writes retire producers, then a new producer re-arms.
    always_comb begin
        busy_nxt = busy;
        for (int unsigned i = 0; i < NWR; i++) begin
            if (wr_hit[i]) begin
                busy_nxt[wa_a[i]] = 1'b0;
            end
        end
        if (set_hit) begin
            busy_nxt[bset_a] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read ports: array lookup, optional bypass, then zero for x0 and during reset.
    always_comb begin
        logic [DATA_W-1:0] rv;
        logic              bv;
`ifdef REGFILE_MP_BYPASS_EN
        logic              byp;
`endif
        rd    = '0;
        rbusy = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            rv = mem[ra_a[j]];
            bv = busy[ra_a[j]];
`ifdef REGFILE_MP_BYPASS_EN
            byp = 1'b0;
            for (int unsigned i = 0; i < NWR; i++) begin
                if (wr_hit[i] && (wa_a[i] == ra_a[j])) begin
                    rv  = wd_a[i];
                    byp = 1'b1;
                end
            end
            if (byp) begin
                bv = set_hit && (bset_a == ra_a[j]);
            end
`endif
            if (!rst_n || (ra_a[j] == '0)) begin
                rv = '0;
                bv = 1'b0;
            end
            rd[j*DATA_W +: DATA_W] = rv;
            rbusy[j]               = bv;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus a randomized
// run compared against an array-based reference model of the register file.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic        bset;
    logic [4:0]  bset_a;
    logic [1:0]  rbusy;

    logic        p_we;
    logic [2:0]  p_wa;
    logic [15:0] p_wd;
    logic [11:0] p_ra;
    logic [63:0] p_rd;
    logic        p_bset;
    logic [2:0]  p_bset_a;
    logic [3:0]  p_rbusy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] m_mem  [32];
    logic        m_busy [32];

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .ra     (ra),
        .rd     (rd),
        .bset   (bset),
        .bset_a (bset_a),
        .rbusy  (rbusy)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4), .NWR(1)) dut_p (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (p_we),
        .wa     (p_wa),
        .wd     (p_wd),
        .ra     (p_ra),
        .rd     (p_rd),
        .bset   (p_bset),
        .bset_a (p_bset_a),
        .rbusy  (p_rbusy)
    );

    task automatic idle();
        we     = '0;
        wa     = '0;
        wd     = '0;
        bset   = 1'b0;
        bset_a = '0;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 32; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    // Apply the clock-edge effect of the current inputs to the model.
    task automatic model_commit();
        logic [4:0] a;
        for (int i = 0; i < 2; i++) begin
            a = wa[i*5 +: 5];
            if (we[i] && a != 5'd0) begin
                m_mem[a]  = wd[i*32 +: 32];
                m_busy[a] = 1'b0;
            end
        end
        if (bset && bset_a != 5'd0) m_busy[bset_a] = 1'b1;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] v;
        if (!rst_n || a == 5'd0) return 32'd0;
        v = m_mem[a];
`ifdef REGFILE_MP_BYPASS_EN
        for (int i = 0; i < 2; i++)
            if (we[i] && wa[i*5 +: 5] == a) v = wd[i*32 +: 32];
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
        for (int i = 0; i < 2; i++)
            if (we[i] && wa[i*5 +: 5] == a) return bset && (bset_a == a);
`endif
        return m_busy[a];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        p_we = 1'b0; p_wa = '0; p_wd = '0; p_ra = '0; p_bset = 1'b0; p_bset_a = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        ra = {5'd3, 5'd5};
        #1;
        total_cnt++;
        if (rd !== 64'd0) $display("FAIL reset_rd: got %h expected %h", rd, 64'd0);
        else pass_cnt++;
        total_cnt++;
        if (rbusy !== 2'b00) $display("FAIL reset_rbusy: got %b expected %b", rbusy, 2'b00);
        else pass_cnt++;
        // write and set requests are ignored while reset is held
        we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'h55; bset = 1'b1; bset_a = 5'd5;
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (rd !== 64'd0 || rbusy !== 2'b00)
            $display("FAIL reset_ignore_we: got rd=%h rbusy=%b expected rd=0 rbusy=0", rd, rbusy);
        else pass_cnt++;
        // write r5 with a concurrent new producer on r5
        we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'hDEADBEEF; bset = 1'b1; bset_a = 5'd5;
        @(posedge clk);
        model_commit();
        @(negedge clk);
        idle();
        #1;
        total_cnt++;
        if (rd[31:0] !== 32'hDEADBEEF || rbusy[0] !== 1'b1)
            $display("FAIL reset_prewrite: got rd=%h rbusy=%b expected rd=deadbeef rbusy=1", rd[31:0], rbusy[0]);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        total_cnt++;
        if (rd[31:0] !== 32'd0 || rbusy !== 2'b00)
            $display("FAIL reset_async: got rd=%h rbusy=%b expected rd=0 rbusy=0", rd[31:0], rbusy);
        else pass_cnt++;
        // a write pending when reset asserts is discarded
        we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (rd[31:0] !== 32'd0) $display("FAIL reset_discard: got %h expected %h", rd[31:0], 32'd0);
        else pass_cnt++;
    endtask

    task automatic test_x0();
        @(negedge clk);
        we = 2'b01; wa[4:0] = 5'd0; wd[31:0] = 32'h12345678; bset = 1'b1; bset_a = 5'd0;
        ra = {5'd0, 5'd0};
        @(posedge clk);
        model_commit();
        @(negedge clk);
        idle();
        #1;
        total_cnt++;
        if (rd !== 64'd0) $display("FAIL x0_rd: got %h expected %h", rd, 64'd0);
        else pass_cnt++;
        total_cnt++;
        if (rbusy !== 2'b00) $display("FAIL x0_rbusy: got %b expected %b", rbusy, 2'b00);
        else pass_cnt++;
    endtask

    task automatic test_conflict();
        @(negedge clk);
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
        ra = {5'd7, 5'd7};
        @(posedge clk);
        model_commit();
        @(negedge clk);
        idle();
        #1;
        total_cnt++;
        if (rd !== {32'h22, 32'h22}) $display("FAIL conflict_rd: got %h expected %h", rd, {32'h22, 32'h22});
        else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        ra = {5'd3, 5'd3};
        bset = 1'b1; bset_a = 5'd3;
        @(posedge clk);
        model_commit();
        @(negedge clk);
        idle();
        #1;
        total_cnt++;
        if (rbusy !== 2'b11) $display("FAIL sb_set: got %b expected %b", rbusy, 2'b11);
        else pass_cnt++;
        we = 2'b01; wa[4:0] = 5'd3; wd[31:0] = 32'hA1; bset = 1'b1; bset_a = 5'd3;
        @(posedge clk);
        model_commit();
        @(negedge clk);
        idle();
        #1;
        total_cnt++;
        if (rbusy !== 2'b11) $display("FAIL sb_race: got %b expected %b", rbusy, 2'b11);
        else pass_cnt++;
        we = 2'b10; wa[9:5] = 5'd3; wd[63:32] = 32'hB2;
        @(posedge clk);
        model_commit();
        @(negedge clk);
        idle();
        #1;
        total_cnt++;
        if (rbusy !== 2'b00 || rd[31:0] !== 32'hB2)
            $display("FAIL sb_clear: got rbusy=%b rd=%h expected rbusy=00 rd=b2", rbusy, rd[31:0]);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        logic [31:0] same_cycle;
`ifdef REGFILE_MP_BYPASS_EN
        same_cycle = 32'hCAFE;
`else
        same_cycle = 32'h0;
`endif
        @(negedge clk);
        ra = {5'd9, 5'd9};
        we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'hCAFE;
        #1;
        total_cnt++;
        if (rd[31:0] !== same_cycle) $display("FAIL bypass_same: got %h expected %h", rd[31:0], same_cycle);
        else pass_cnt++;
        total_cnt++;
        if (rbusy[0] !== 1'b0) $display("FAIL bypass_busy: got %b expected %b", rbusy[0], 1'b0);
        else pass_cnt++;
        @(posedge clk);
        model_commit();
        @(negedge clk);
        idle();
        #1;
        total_cnt++;
        if (rd[31:0] !== 32'hCAFE) $display("FAIL bypass_next: got %h expected %h", rd[31:0], 32'hCAFE);
        else pass_cnt++;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom);
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        logic [4:0] a;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we     = 2'($urandom);
            wa     = {rand_addr(), rand_addr()};
            wd     = {32'($urandom), 32'($urandom)};
            bset   = 1'($urandom);
            bset_a = rand_addr();
            ra     = {rand_addr(), rand_addr()};
            #1;
            for (int j = 0; j < 2; j++) begin
                a = ra[j*5 +: 5];
                total_cnt++;
                if (rd[j*32 +: 32] !== exp_rd(a))
                    $display("FAIL rand_rd[%0d] cyc %0d addr %0d: got %h expected %h", j, n, a, rd[j*32 +: 32], exp_rd(a));
                else pass_cnt++;
                total_cnt++;
                if (rbusy[j] !== exp_busy(a))
                    $display("FAIL rand_busy[%0d] cyc %0d addr %0d: got %b expected %b", j, n, a, rbusy[j], exp_busy(a));
                else pass_cnt++;
            end
            @(posedge clk);
            model_commit();
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_params();
        @(negedge clk);
        p_ra = {3'd7, 3'd7, 3'd7, 3'd7};
        p_we = 1'b1; p_wa = 3'd7; p_wd = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        p_we = 1'b0;
        #1;
        total_cnt++;
        if (p_rd !== {4{16'hBEEF}}) $display("FAIL param_rd: got %h expected %h", p_rd, {4{16'hBEEF}});
        else pass_cnt++;
        total_cnt++;
        if (p_rbusy !== 4'b0000) $display("FAIL param_rbusy: got %b expected %b", p_rbusy, 4'b0000);
        else pass_cnt++;
    endtask

    initial begin
        ra = '0;
        test_reset();
        test_x0();
        test_conflict();
        test_scoreboard();
        test_bypass();
        test_params();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL provide parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL provide parameter NWR, default 2, number of write ports (1..2).
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock, all state updates on rising edge.
REQ-006 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have we  in  NWR  per-port write enable.
REQ-008 SHALL have wa  in  NWR*ADDR_W  write addresses, port i in bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have wd  in  NWR*DATA_W  write data, same packing.
REQ-010 SHALL have ra  in  NRD*ADDR_W  read addresses, same packing.
REQ-011 SHALL have rd  out  NRD*DATA_W  read data, same packing.
REQ-012 SHALL have bset  in  1  scoreboard set request (in-flight producer issued).
REQ-013 SHALL have bset_a  in  ADDR_W  scoreboard set address.
REQ-014 SHALL have rbusy  out  NRD  per-read-port busy flag of addressed register.

Function
REQ-015 SHALL hold 2**ADDR_W registers of DATA_W bits; register 0 SHALL read as 0 on every port and never be written.
REQ-016 SHALL write wd[i] to register wa[i] on the rising clk edge when we[i]=1 and wa[i]!=0.
REQ-017 SHALL, when two write ports target the same nonzero address in one cycle, store data of the higher-indexed port only.
REQ-018 SHALL drive rd[j] combinationally from register ra[j]; zero-latency read, no read enable.
REQ-019 SHALL maintain one busy bit per register; busy bit set on rising edge when bset=1 and bset_a!=0.
REQ-020 SHALL clear busy bit of wa[i] on rising edge when we[i]=1 and wa[i]!=0.
REQ-021 SHALL, when set and clear hit the same address in one cycle, leave the bit set (new producer wins).
REQ-022 SHALL drive rbusy[j] combinationally from busy bit of ra[j]; rbusy[j]=0 whenever ra[j]=0.
REQ-023 SHALL never mark register 0 busy; bset with bset_a=0 is ignored.
REQ-024 SHALL treat address wrap by construction: all ADDR_W-bit addresses valid, no out-of-range case.

Reset
REQ-025 SHALL clear all registers to 0 and all busy bits to 0 immediately when rst_n=0, independent of clk.
REQ-026 SHALL present rd=0 and rbusy=0 on all ports while rst_n=0.
REQ-027 SHALL ignore we and bset while rst_n=0; first write accepted on the first rising clk edge after rst_n deasserts.
REQ-028 SHALL discard a write in progress when reset asserts mid-cycle; no partial update survives.

Configuration
REQ-029 SHALL compile write-to-read bypass when macro REGFILE_MP_BYPASS_EN is defined: rd[j] returns wd[i] of the highest-indexed port with we[i]=1, wa[i]==ra[j]!=0 in the same cycle, and rbusy[j] reads 0 for that address unless bset targets it.
REQ-030 SHALL, without REGFILE_MP_BYPASS_EN, return pre-edge register contents and pre-edge busy state in the write cycle (new value visible the following cycle).

Verification
REQ-031 SHALL cover reset: write 0xDEADBEEF to r5, assert rst_n=0 between edges -> rd for ra=5 reads 0 immediately, rbusy=0.
REQ-032 SHALL cover x0: we[0]=1, wa=0, wd=0x12345678; bset_a=0 -> next cycle rd(ra=0)=0, rbusy=0.
REQ-033 SHALL cover write conflict: port0 writes 0x11 and port1 writes 0x22 to r7 same cycle -> next cycle rd(ra=7)=0x22.
REQ-034 SHALL cover scoreboard race: bset on r3 cycle N, write r3 with bset on r3 cycle N+1 -> rbusy=1 after N+1; write r3 alone cycle N+2 -> rbusy=0 after N+2.
REQ-035 SHALL cover bypass: write 0xCAFE to r9 while ra=9 -> rd=0xCAFE same cycle with REGFILE_MP_BYPASS_EN, old value (0) without.
REQ-036 SHALL cover parametrisation: DATA_W=16, ADDR_W=3, NRD=4, NWR=1 -> write r7=0xBEEF, all four ports with ra=7 read 0xBEEF next cycle.
